// File: rtl/ksa_pkg.sv
// -----------------------------------------------------------------------------
// ksa_pkg
// Shared types and helpers for the pipelined Kogge-Stone adder.
//   gp_t        : per-bit {generate, propagate} pair
//   prefix_op   : Kogge-Stone combine of a high group with a lower group
//   num_stages  : number of prefix pipeline stages, ceil(log2(width)/reg_every)
// -----------------------------------------------------------------------------
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // The high group generates if it generates itself, or propagates a
    // generate from the low group; it propagates only if both do.
    function automatic gp_t prefix_op(input logic g_hi, input logic p_hi,
                                      input logic g_lo, input logic p_lo);
        gp_t r;
        r.g = g_hi | (p_hi & g_lo);
        r.p = p_hi & p_lo;
        return r;
    endfunction

    function automatic int num_stages(input int width, input int reg_every);
        return ($clog2(width) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// -----------------------------------------------------------------------------
// ksa_prefix_level
// One combinational Kogge-Stone prefix level. Bit i combines with bit i-DIST;
// the lowest DIST bits already hold their final group values and pass through.
// Ports:
//   g_in,  p_in  : group generate/propagate from the previous level
//   g_out, p_out : group generate/propagate after this level
// -----------------------------------------------------------------------------
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_comb
            gp_t gp;
            assign gp       = prefix_op(g_in[i], p_in[i], g_in[i-DIST], p_in[i-DIST]);
            assign g_out[i] = gp.g;
            assign p_out[i] = gp.p;
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/ksa_pipe_adder.sv
// -----------------------------------------------------------------------------
// ksa_pipe_adder
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// A register bank follows the p/g stage, then one after every REG_EVERY prefix
// levels; the final bank holds sum/cout/ovf. Latency is num_stages()+1 cycles.
// A single advance enable moves the whole pipe, so a stall freezes every stage.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : input handshake (in_ready = pipe may advance)
//   in_a, in_b               : operands
//   in_cin                   : carry-in (ignored when subtracting)
//   in_sub                   : 1 = in_a - in_b
//   out_valid / out_ready    : output handshake
//   out_sum                  : result modulo 2^WIDTH
//   out_cout                 : carry-out (subtract: 1 = no borrow)
//   out_ovf                  : signed overflow
// -----------------------------------------------------------------------------
module ksa_pipe_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int L = $clog2(WIDTH);
    localparam int N = num_stages(WIDTH, REG_EVERY);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---- S0: operand conditioning and bitwise p/g ----
    logic [WIDTH-1:0] bb_s0, p_s0, g_s0;
    logic             c0_s0;

    assign bb_s0 = in_b ^ {WIDTH{in_sub}};
    assign c0_s0 = in_sub | in_cin;
    assign p_s0  = in_a ^ bb_s0;
    assign g_s0  = in_a & bb_s0;

    // Register bank k feeds prefix stage k+1. pp_p is the group propagate,
    // op_p the original bit propagate needed for the final sum.
    logic [WIDTH-1:0] g_p  [0:N-1];
    logic [WIDTH-1:0] pp_p [0:N-1];
    logic [WIDTH-1:0] op_p [0:N-1];
    logic             c0_p [0:N-1];
    logic             vld_p[0:N-1];

    // ---- S1..SN: prefix levels ----
    logic [WIDTH-1:0] lg [1:L];
    logic [WIDTH-1:0] lp [1:L];

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        logic [WIDTH-1:0] gi, pi;
        // The first level of each stage reads the register bank, the rest chain.
        if ((j - 1) % REG_EVERY == 0) begin : g_from_reg
            assign gi = g_p [(j-1)/REG_EVERY];
            assign pi = pp_p[(j-1)/REG_EVERY];
        end else begin : g_from_lvl
            assign gi = lg[j-1];
            assign pi = lp[j-1];
        end
        ksa_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (j - 1))
        ) u_lvl (
            .g_in  (gi),
            .p_in  (pi),
            .g_out (lg[j]),
            .p_out (lp[j])
        );
    end

    // ---- SN: carries, sum, carry-out, overflow ----
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry = {lg[L] | (lp[L] & {WIDTH{c0_p[N-1]}}), c0_p[N-1]};
    assign sum_c = op_p[N-1] ^ carry[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) vld_p[k] <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < N; k++) vld_p[k] <= vld_p[k-1];
            out_valid <= vld_p[N-1];
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            g_p[0]  <= g_s0;
            pp_p[0] <= p_s0;
            op_p[0] <= p_s0;
            c0_p[0] <= c0_s0;
            for (int k = 1; k < N; k++) begin
                g_p[k]  <= lg[k*REG_EVERY];
                pp_p[k] <= lp[k*REG_EVERY];
                op_p[k] <= op_p[k-1];
                c0_p[k] <= c0_p[k-1];
            end
        end
    end

    // Output bank is reset so the result bus reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (adv) begin
            out_sum  <= sum_c;
            out_cout <= carry[WIDTH];
            out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_ksa_pipe_adder
// Bench for ksa_pipe_adder: a 32-bit/REG_EVERY=2 instance for directed,
// flow-control and reset scenarios, plus six instances (8/16/64 bits,
// REG_EVERY 1 and L) driven together by a random stream.
// -----------------------------------------------------------------------------
module tb_ksa_pipe_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance ----------------
    logic        rst, in_valid, in_ready, in_cin, in_sub;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] in_a, in_b, out_sum;

    ksa_pipe_adder #(.WIDTH(32), .REG_EVERY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // ---------------- sweep instances ----------------
    localparam int NSW = 6;
    localparam int SW [NSW] = '{8, 8, 16, 16, 64, 64};
    localparam int SR [NSW] = '{1, 3, 1, 4, 1, 6};
    localparam int SL [NSW] = '{4, 2, 5, 2, 7, 2};

    logic        sw_rst, sw_valid, sw_cin, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic        sw_rdy [NSW];
    logic        sw_ov  [NSW];
    logic        sw_co  [NSW];
    logic        sw_of  [NSW];
    logic [63:0] sw_sum [NSW];

    for (genvar k = 0; k < NSW; k++) begin : g_sw
        logic [SW[k]-1:0] s;
        ksa_pipe_adder #(.WIDTH(SW[k]), .REG_EVERY(SR[k])) u (
            .clk       (clk),
            .rst       (sw_rst),
            .in_valid  (sw_valid),
            .in_ready  (sw_rdy[k]),
            .in_a      (sw_a[SW[k]-1:0]),
            .in_b      (sw_b[SW[k]-1:0]),
            .in_cin    (sw_cin),
            .in_sub    (sw_sub),
            .out_valid (sw_ov[k]),
            .out_ready (1'b1),
            .out_sum   (s),
            .out_cout  (sw_co[k]),
            .out_ovf   (sw_of[k])
        );
        assign sw_sum[k] = 64'(s);
    end

    // Reference: integer arithmetic on w-bit values, unsigned for sum/cout,
    // signed for overflow (result outside the w-bit two's complement range).
    function automatic res_t model(input int w, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic cin,
                                   input logic sub);
        res_t r;
        logic [63:0] mask, a, b;
        logic signed [67:0] ua, ub, sa, sb, u, s, lim, cx, one;
        one  = 68'sd1;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        ua   = $signed({4'b0, a});
        ub   = $signed({4'b0, b});
        sa   = ua;
        sb   = ub;
        if (a[w-1]) sa = ua - (one <<< w);
        if (b[w-1]) sb = ub - (one <<< w);
        cx = $signed({67'b0, cin});
        if (sub) begin
            u      = ua - ub;
            s      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + cx;
            s      = sa + sb + cx;
            r.cout = (u >= (one <<< w));
        end
        r.sum = u[63:0] & mask;
        lim   = one <<< (w - 1);
        r.ovf = (s >= lim) || (s < -lim);
        return r;
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 7))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0;
            2:       return 64'h7F7F_7F7F_7F7F_7F7F;
            3:       return 64'h8080_8080_8080_8080;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------------------------------------------------------
    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %0b want 0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %0b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        // The input presented during reset must never emerge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drop cycle %0d out_valid got %0b want 0", i, out_valid); end
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5,         32'h8000_0000, 32'h1234, 32'h10};
        logic [31:0] tb [6] = '{32'h1,         32'h1,         32'h7,         32'h1,         32'h4321, 32'h3};
        logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] es [6] = '{32'h0,         32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h5556, 32'hD};
        logic        ec [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        logic found;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = ta[i]; in_b = tb[i]; in_cin = tc[i]; in_sub = ts[i];
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %0b want 1", i, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0; found = 1'b0;
            while (n < 12 && !found) begin
                @(negedge clk);
                n++;
                if (out_valid === 1'b1) found = 1'b1;
            end
            checks++; if (!found || n != 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, found ? n : -1); end
            checks++; if (out_sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, out_sum, es[i]); end
            checks++; if (out_cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %0b want %0b", i, out_cout, ec[i]); end
            checks++; if (out_ovf !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %0b want %0b", i, out_ovf, eo[i]); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_single got out_valid %0b want 0", i, out_valid); end
        end
    endtask

    // mode 0: continuous stream with out_ready low for exactly 3 cycles.
    // mode 1: random input gaps and random out_ready.
    task automatic test_back_to_back(input int mode, input int nops);
        res_t q[$];
        res_t r;
        int sent = 0, got = 0, cyc = 0, holds = 0;
        logic pend = 1'b0, stalled = 1'b0;
        logic [31:0] a = '0, b = '0, hs = '0;
        logic ci = 1'b0, sb = 1'b0, hc = 1'b0, ho = 1'b0;
        while (got < nops && cyc < 3000) begin
            @(posedge clk); #1;
            if (!pend && sent < nops && (mode == 0 || $urandom_range(0, 3) != 0)) begin
                a = $urandom; b = $urandom; ci = 1'($urandom); sb = 1'($urandom);
                pend = 1'b1;
            end
            in_valid = pend; in_a = a; in_b = b; in_cin = ci; in_sub = sb;
            out_ready = (mode == 0) ? !(cyc >= 6 && cyc < 9) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL b2b%0d_in_ready cyc %0d got %0b want %0b", mode, cyc, in_ready, !out_valid || out_ready); end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_sum !== hs || out_cout !== hc || out_ovf !== ho) begin
                    errors++; $display("FAIL b2b%0d_hold cyc %0d got %0b/%h/%0b/%0b want 1/%h/%0b/%0b", mode, cyc, out_valid, out_sum, out_cout, out_ovf, hs, hc, ho);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) holds++;
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model(32, {32'b0, a}, {32'b0, b}, ci, sb));
                sent++; pend = 1'b0;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b%0d_extra cyc %0d got result %h want none", mode, cyc, out_sum);
                end else begin
                    r = q.pop_front();
                    if (out_sum !== r.sum[31:0] || out_cout !== r.cout || out_ovf !== r.ovf) begin
                        errors++; $display("FAIL b2b%0d_result #%0d got %h/%0b/%0b want %h/%0b/%0b", mode, got, out_sum, out_cout, out_ovf, r.sum[31:0], r.cout, r.ovf);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            hs = out_sum; hc = out_cout; ho = out_ovf;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != nops) begin errors++; $display("FAIL b2b%0d_count got %0d want %0d", mode, got, nops); end
        if (mode == 0) begin
            checks++; if (holds != 3) begin errors++; $display("FAIL b2b0_stall_cycles got %0d want 3", holds); end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b%0d_drain cycle %0d out_valid got %0b want 0", mode, i, out_valid); end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_cin = 1'b0; in_sub = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_pre_reset out_valid got %0b want 0", out_valid); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %0b want 1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d out_valid got %0b want 0", i, out_valid); end
        end
    endtask

    task automatic test_sweep(input int ncyc);
        logic        hv [8];
        logic [63:0] ha [8], hb [8];
        logic        hc [8], hs [8];
        int idx;
        logic ev;
        res_t r;
        for (int i = 0; i < 8; i++) begin hv[i] = 1'b0; ha[i] = '0; hb[i] = '0; hc[i] = 1'b0; hs[i] = 1'b0; end
        sw_rst = 1'b1; sw_valid = 1'b0;
        repeat (2) @(posedge clk);
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk); #1;
            sw_rst   = 1'b0;
            sw_valid = ($urandom_range(0, 7) != 0);
            sw_a     = pick64();
            sw_b     = pick64();
            sw_cin   = 1'($urandom);
            sw_sub   = 1'($urandom);
            @(negedge clk);
            for (int k = 0; k < NSW; k++) begin
                checks++; if (sw_rdy[k] !== 1'b1) begin errors++; $display("FAIL sw%0d_in_ready t %0d got %0b want 1", k, t, sw_rdy[k]); end
                idx = (t - SL[k] + 8) % 8;
                ev  = (t >= SL[k]) ? hv[idx] : 1'b0;
                checks++; if (sw_ov[k] !== ev) begin errors++; $display("FAIL sw%0d_valid t %0d got %0b want %0b", k, t, sw_ov[k], ev); end
                if (ev) begin
                    r = model(SW[k], ha[idx], hb[idx], hc[idx], hs[idx]);
                    checks++;
                    if (sw_sum[k] !== r.sum || sw_co[k] !== r.cout || sw_of[k] !== r.ovf) begin
                        errors++; $display("FAIL sw%0d_result t %0d got %h/%0b/%0b want %h/%0b/%0b", k, t, sw_sum[k], sw_co[k], sw_of[k], r.sum, r.cout, r.ovf);
                    end
                end
            end
            hv[t % 8] = sw_valid; ha[t % 8] = sw_a; hb[t % 8] = sw_b;
            hc[t % 8] = sw_cin;   hs[t % 8] = sw_sub;
        end
        sw_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        sw_rst = 1'b1; sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back(0, 8);
        test_back_to_back(1, 300);
        test_reset_midstream();
        test_sweep(11000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
